// File: rtl/f2i_arbiter.sv
// -----------------------------------------------------------------------------
// f2i_arbiter
//
// Purpose:
//   Shares one external float-to-int converter among NREQ requesters.
//   Arbitration is round-robin. The search starts at the requester after the
//   one served last. The winner's IEEE-754 operand is captured into
//   conv_float, the converter is started for one cycle, and the block waits
//   for conv_done. The signed 16-bit result is then returned with a one-cycle
//   ack to the winner. If the winner dropped its request meanwhile, the result
//   is discarded and no ack is sent.
//
// Parameters:
//   NREQ     number of requesters (2..8)
//   TIMEOUT  WAIT-cycle watchdog limit (only used with F2I_ARB_TIMEOUT_EN)
//
// Configuration macro:
//   F2I_ARB_TIMEOUT_EN  when defined, a watchdog counts WAIT cycles. After
//                       TIMEOUT cycles without conv_done the requester is
//                       acked with out_int=0 and err=1. When undefined, WAIT
//                       waits forever and err is tied low.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous active-high reset
//   req         per-requester request level [NREQ]
//   req_float   per-requester operand, slice i = [32i+31:32i]
//   ack         one-hot completion pulse (RESP cycle only)
//   out_int     signed result, held between responses
//   busy        high whenever not IDLE
//   grant_id    index of the requester being served
//   err         watchdog flag, pulsed together with ack
//   conv_start  converter start strobe (ISSUE cycle)
//   conv_float  registered operand to the converter
//   conv_int    converter signed result
//   conv_done   converter completion flag
// -----------------------------------------------------------------------------
module f2i_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [32*NREQ-1:0]       req_float,
    output logic [NREQ-1:0]          ack,
    output logic signed [15:0]       out_int,
    output logic                     busy,
    output logic [2:0]               grant_id,
    output logic                     err,
    output logic                     conv_start,
    output logic [31:0]              conv_float,
    input  logic signed [15:0]       conv_int,
    input  logic                     conv_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         grant_q, grant_d;
    logic [2:0]         last_q, last_d;
    logic [31:0]        float_q, float_d;
    logic signed [15:0] out_q, out_d;

`ifdef F2I_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0]    wd_q, wd_d;
    logic               tmo_q, tmo_d;
`endif

    // Requests padded to 8 bits so a 3-bit index is always in range.
    logic [7:0]         req_pad;
    logic [7:0]         grant_oh;
    logic [2:0]         winner;
    logic [31:0]        float_sel;

    assign req_pad  = 8'(req);
    assign grant_oh = 8'(1) << grant_q;

    // Round-robin search. It starts at last_q+1 and wraps modulo NREQ.
    // last_q+1+i never exceeds 2*NREQ-1, so one conditional subtraction
    // is enough for the wrap.
    always_comb begin
        logic       found;
        logic [3:0] idx;
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = {1'b0, last_q} + 4'd1 + 4'(i);
            if (idx >= 4'(NREQ)) begin
                idx = idx - 4'(NREQ);
            end
            if (!found && req_pad[idx[2:0]]) begin
                found  = 1'b1;
                winner = idx[2:0];
            end
        end
    end

    // Operand mux for the round-robin winner.
    always_comb begin
        float_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (winner == 3'(i)) begin
                float_sel = req_float[i*32 +: 32];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        float_d = float_q;
        out_d   = out_q;
`ifdef F2I_ARB_TIMEOUT_EN
        tmo_d   = tmo_q;
        wd_d    = '0;
`endif
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    grant_d = winner;
                    float_d = float_sel;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (conv_done) begin
                    out_d   = conv_int;
                    state_d = S_RESP;
                end
`ifdef F2I_ARB_TIMEOUT_EN
                else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    // wd_q counts completed WAIT cycles. This is the
                    // TIMEOUT-th WAIT cycle without conv_done.
                    out_d   = '0;
                    tmo_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
`endif
            end
            S_RESP: begin
                // last_grant advances even when the requester withdrew.
                last_d  = grant_q;
                state_d = S_IDLE;
`ifdef F2I_ARB_TIMEOUT_EN
                tmo_d   = 1'b0;
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            last_q  <= 3'(NREQ - 1);
            float_q <= '0;
            out_q   <= '0;
`ifdef F2I_ARB_TIMEOUT_EN
            wd_q    <= '0;
            tmo_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            float_q <= float_d;
            out_q   <= out_d;
`ifdef F2I_ARB_TIMEOUT_EN
            wd_q    <= wd_d;
            tmo_q   <= tmo_d;
`endif
        end
    end

    // A requester that dropped req before RESP gets no ack.
    assign ack        = (state_q == S_RESP) ? (req & grant_oh[NREQ-1:0]) : '0;
    assign out_int    = out_q;
    assign busy       = (state_q != S_IDLE);
    assign grant_id   = grant_q;
    assign conv_start = (state_q == S_ISSUE);
    assign conv_float = float_q;

`ifdef F2I_ARB_TIMEOUT_EN
    assign err = (|ack) & tmo_q;
`else
    // TIMEOUT has no effect without the watchdog.
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
    assign err = 1'b0;
`endif

endmodule

// File: doc/f2i_arbiter.md
F2I_ARBITER -- requirements
Module: f2i_arbiter

Interface
- REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of requesters (2..8).
- REQ-002 The block SHALL have parameter TIMEOUT, default 15, giving the WAIT-cycle watchdog limit (used only with F2I_ARB_TIMEOUT_EN).
- REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
- REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
- REQ-005 The block SHALL have port req, input, NREQ bits: per-requester conversion request, level.
- REQ-006 The block SHALL have port req_float, input, 32*NREQ bits: IEEE-754 single per requester; slice i is bits [32i+31:32i].
- REQ-007 The block SHALL have port ack, output, NREQ bits: one-hot, one-cycle completion pulse.
- REQ-008 The block SHALL have port out_int, output, 16 bits: signed result, valid while any ack bit is high.
- REQ-009 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.
- REQ-010 The block SHALL have port grant_id, output, 3 bits: index of the requester currently being served.
- REQ-011 The block SHALL have port err, output, 1 bit: timeout flag pulsed with ack; constant 0 without the macro.
- REQ-012 The block SHALL have port conv_start, output, 1 bit: drives the shared converter's load/start input.
- REQ-013 The block SHALL have port conv_float, output, 32 bits: registered operand to the converter.
- REQ-014 The block SHALL have port conv_int, input, 16 bits: converter signed result.
- REQ-015 The block SHALL have port conv_done, input, 1 bit: converter completion flag.

Function
- REQ-016 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP.
- REQ-017 In IDLE with req != 0, the block SHALL pick a winner round-robin, searching from last_grant+1 modulo NREQ; it SHALL latch grant_id, latch conv_float from that requester's slice, and go to ISSUE.
- REQ-018 ISSUE SHALL last exactly one cycle with conv_start=1, then go to WAIT; conv_start SHALL be 0 in all other states.
- REQ-019 WAIT SHALL ignore conv_done in the ISSUE cycle and sample it from the first WAIT cycle; on conv_done=1 it SHALL register conv_int into out_int and go to RESP.
- REQ-020 RESP SHALL last one cycle: if req[grant_id]=1, ack[grant_id]=1; if req[grant_id]=0 (requester withdrew), no ack is issued and the result is discarded. RESP SHALL then update last_grant:=grant_id and return to IDLE.
- REQ-021 Latency from the IDLE cycle in which a request is sampled to ack SHALL be 3 cycles when the converter is done on the first WAIT cycle, and 4 cycles when it needs one extra cycle.
- REQ-022 Requesters SHALL hold req and req_float stable until ack; a req still high in the cycle after ack SHALL be treated as a new request.
- REQ-023 Changes to req or req_float after grant SHALL NOT affect conv_float or the issued conversion.
- REQ-024 A newly asserted req while busy SHALL wait and be considered only in the next IDLE cycle; requests are never lost while held.
- REQ-025 With all requesters continuously asserting, grants SHALL rotate 0,1,...,NREQ-1,0; no requester waits more than NREQ services.
- REQ-026 out_int SHALL hold its last value outside RESP; ack and err SHALL be 0 outside RESP.

Reset
- REQ-027 On reset=1 at a clock edge: state:=IDLE, ack:=0, err:=0, conv_start:=0, conv_float:=0, out_int:=0, grant_id:=0, last_grant:=NREQ-1 (requester 0 wins first), watchdog:=0.
- REQ-028 Reset during ISSUE or WAIT SHALL abandon the conversion without ack; any late conv_done SHALL be ignored while in IDLE.

Configuration
- REQ-029 With F2I_ARB_TIMEOUT_EN defined, a counter SHALL run in WAIT; if conv_done is still 0 after TIMEOUT WAIT cycles, the block SHALL go to RESP with out_int:=0 and err=1 together with the ack.
- REQ-030 Without F2I_ARB_TIMEOUT_EN, WAIT SHALL wait indefinitely, err SHALL be tied to 0, and no counter logic SHALL be built.

Verification
- REQ-031 Single request: req=0001, float 0x40A00000 (5.0), converter returns 5 on the 2nd WAIT cycle -> ack=0001 with out_int=5 four cycles after request; busy low next cycle.
- REQ-032 Contention: req=1111 held continuously -> ack order 0001,0010,0100,1000,0001; each out_int matches its requester's value.
- REQ-033 Withdrawal: req[2] dropped during WAIT -> no ack pulse; next IDLE serves the next pending requester; last_grant=2.
- REQ-034 Reset in WAIT: reset one cycle, then conv_done=1 -> no ack, state IDLE; after reset, req=1010 -> requester 1 is granted first.
- REQ-035 Timeout (macro on, TIMEOUT=15): conv_done held 0 -> ack with err=1 and out_int=0 after 15 WAIT cycles; macro off -> busy stays high and no ack.
- REQ-036 Stability: req_float[0] changed in the ISSUE cycle -> conv_float keeps the value latched at grant.
